// File: rtl/wb_write_scheduler_pkg.sv
// Shared types and helpers for the write-back scheduler.
// Requester ids, widths and the one-hot destination decode.
package wb_write_scheduler_pkg;
    localparam int NREQ  = 3;
    localparam int DW    = 32;
    localparam int NREG  = 8;
    localparam int DESTW = 3;
    localparam int CNTW  = 16;

    localparam logic [1:0] REQ_ALU0 = 2'd0;
    localparam logic [1:0] REQ_ALU1 = 2'd1;
    localparam logic [1:0] REQ_LOAD = 2'd2;

    function automatic logic [NREG-1:0] dec3to8(input logic [DESTW-1:0] d);
        logic [NREG-1:0] oh;
        oh    = '0;
        oh[d] = 1'b1;
        return oh;
    endfunction

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == REQ_LOAD) ? REQ_ALU0 : x + 2'd1;
    endfunction
endpackage

// File: rtl/wb_write_scheduler_rr_pick2.sv
// Combinational round-robin picker: grants the first two eligible
// requesters scanning from rr, and reports the rr that follows them.
module wb_rr_pick2
    import wb_write_scheduler_pkg::*;
(
    input  logic [2:0] elig_i,
    input  logic [1:0] rr_i,
    output logic       g0_v_o,
    output logic [1:0] g0_idx_o,
    output logic       g1_v_o,
    output logic [1:0] g1_idx_o,
    output logic [1:0] next_rr_o
);
    logic [1:0] cur;

    always_comb begin
        g0_v_o    = 1'b0;
        g0_idx_o  = 2'd0;
        g1_v_o    = 1'b0;
        g1_idx_o  = 2'd0;
        next_rr_o = rr_i;
        cur       = (rr_i == 2'd3) ? REQ_ALU0 : rr_i;
        for (int k = 0; k < NREQ; k++) begin
            if (elig_i[cur]) begin
                if (!g0_v_o) begin
                    g0_v_o    = 1'b1;
                    g0_idx_o  = cur;
                    next_rr_o = inc3(cur);
                end else if (!g1_v_o) begin
                    g1_v_o    = 1'b1;
                    g1_idx_o  = cur;
                    next_rr_o = inc3(cur);
                end
            end
            cur = inc3(cur);
        end
    end
endmodule

// File: rtl/wb_write_scheduler.sv
// Write-back scheduler: masks same-register conflicts, allocates two
// register-file write ports round-robin and drops R0 writes.
module wb_write_scheduler
    import wb_write_scheduler_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DESTW-1:0] req_dest,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 regWrite1,
    output logic [NREG-1:0]      decOut1,
    output logic [DW-1:0]        writeData1,
    output logic                 regWrite2,
    output logic [NREG-1:0]      decOut2,
    output logic [DW-1:0]        writeData2,
    output logic [NREG-1:0]      wr_busy,
    output logic [CNTW-1:0]      r0_drop_cnt
);
    logic [DESTW-1:0] dst [NREQ];
    logic [NREQ-1:0]  is_r0;
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  gnt;
    logic             blk;

    logic             g0_v, g1_v;
    logic [1:0]       g0_idx, g1_idx, next_rr;
    logic [1:0]       p1_idx, p2_idx;

    logic [1:0]       rr_q, rr_d;
    logic             rw1_q, rw1_d, rw2_q, rw2_d;
    logic [NREG-1:0]  dec1_q, dec1_d, dec2_q, dec2_d;
    logic [DW-1:0]    wd1_q, wd1_d, wd2_q, wd2_d;
    logic [NREG-1:0]  busy_q, busy_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CNTW:0]    cnt_sum;
    logic [1:0]       r0_n;

    // Only the oldest valid writer of a given non-zero register competes.
    always_comb begin
        is_r0 = '0;
        elig  = '0;
        blk   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            dst[i] = req_dest[DESTW*i +: DESTW];
        end
        for (int i = 0; i < NREQ; i++) begin
            blk = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (req_valid[j] && dst[j] == dst[i]) blk = 1'b1;
            end
            is_r0[i] = req_valid[i] && dst[i] == '0;
            elig[i]  = req_valid[i] && dst[i] != '0 && !blk;
        end
    end

    wb_rr_pick2 u_pick (
        .elig_i    (elig),
        .rr_i      (rr_q),
        .g0_v_o    (g0_v),
        .g0_idx_o  (g0_idx),
        .g1_v_o    (g1_v),
        .g1_idx_o  (g1_idx),
        .next_rr_o (next_rr)
    );

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = (g0_v && g0_idx == 2'(i)) || (g1_v && g1_idx == 2'(i));
        end
    end

    assign req_ready = {NREQ{reset}} & (is_r0 | gnt);

    // Port 1 always carries the lower requester index.
    always_comb begin
        p1_idx = g0_idx;
        p2_idx = g1_idx;
        if (g1_v && g1_idx < g0_idx) begin
            p1_idx = g1_idx;
            p2_idx = g0_idx;
        end
    end

    always_comb begin
        rw1_d  = g0_v;
        rw2_d  = g1_v;
        dec1_d = g0_v ? dec3to8(dst[p1_idx]) : '0;
        dec2_d = g1_v ? dec3to8(dst[p2_idx]) : '0;
        wd1_d  = g0_v ? req_data[DW*int'(p1_idx) +: DW] : wd1_q;
        wd2_d  = g1_v ? req_data[DW*int'(p2_idx) +: DW] : wd2_q;
        busy_d = dec1_d | dec2_d;
        rr_d   = g0_v ? next_rr : rr_q;
        r0_n   = 2'(is_r0[0]) + 2'(is_r0[1]) + 2'(is_r0[2]);
        cnt_sum = {1'b0, cnt_q} + (CNTW+1)'(r0_n);
        cnt_d  = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q   <= '0;
            rw1_q  <= 1'b0;
            rw2_q  <= 1'b0;
            dec1_q <= '0;
            dec2_q <= '0;
            wd1_q  <= '0;
            wd2_q  <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            rr_q   <= rr_d;
            rw1_q  <= rw1_d;
            rw2_q  <= rw2_d;
            dec1_q <= dec1_d;
            dec2_q <= dec2_d;
            wd1_q  <= wd1_d;
            wd2_q  <= wd2_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign regWrite1   = rw1_q;
    assign decOut1     = dec1_q;
    assign writeData1  = wd1_q;
    assign regWrite2   = rw2_q;
    assign decOut2     = dec2_q;
    assign writeData2  = wd2_q;
    assign wr_busy     = busy_q;
    assign r0_drop_cnt = cnt_q;
endmodule

// File: tb/tb_wb_write_scheduler.sv
// Bench for wb_write_scheduler: directed scenarios plus held-valid
// random traffic against a cycle-level reference model.
module tb_wb_write_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [8:0]  req_dest;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        regWrite1, regWrite2;
    logic [7:0]  decOut1, decOut2, wr_busy;
    logic [31:0] writeData1, writeData2;
    logic [15:0] r0_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int          m_rr, m_cnt;
    bit          m_rw1, m_rw2;
    int          m_d1, m_d2;
    logic [31:0] m_wd1, m_wd2;
    logic [2:0]  m_acc;
    logic [31:0] mrf [8];
    logic [31:0] rf  [8];

    always #5 clk = ~clk;

    wb_write_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_dest    (req_dest),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .regWrite1   (regWrite1),
        .decOut1     (decOut1),
        .writeData1  (writeData1),
        .regWrite2   (regWrite2),
        .decOut2     (decOut2),
        .writeData2  (writeData2),
        .wr_busy     (wr_busy),
        .r0_drop_cnt (r0_drop_cnt)
    );

    // register set fed by the DUT write ports
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (regWrite1 && decOut1[k]) rf[k] <= writeData1;
            if (regWrite2 && decOut2[k]) rf[k] <= writeData2;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int dst_of(int i);
        return int'(req_dest[3*i +: 3]);
    endfunction

    task automatic cyc(input logic r);
        int  ng, r0n, lo, hi, idx;
        int  g [2];
        bit  el [3];
        int  last;
        reset = r;
        #1;
        ng = 0; r0n = 0; last = 0;
        m_acc = 3'b000;
        for (int i = 0; i < 3; i++) begin
            el[i] = 1'b0;
            if (req_valid[i]) begin
                if (dst_of(i) == 0) begin
                    r0n++;
                    m_acc[i] = 1'b1;
                end else begin
                    el[i] = 1'b1;
                    for (int j = 0; j < i; j++)
                        if (req_valid[j] && dst_of(j) == dst_of(i)) el[i] = 1'b0;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            idx = (m_rr + k) % 3;
            if (el[idx] && ng < 2) begin
                g[ng] = idx;
                ng++;
                last = idx;
                m_acc[idx] = 1'b1;
            end
        end
        if (!r) m_acc = 3'b000;
        chk("ready", 64'(req_ready), 64'(m_acc));
        @(posedge clk);
        if (m_rw1) mrf[m_d1] = m_wd1;
        if (m_rw2) mrf[m_d2] = m_wd2;
        if (!r) begin
            m_rr = 0; m_cnt = 0;
            m_rw1 = 0; m_rw2 = 0;
            m_wd1 = '0; m_wd2 = '0;
        end else begin
            m_rw1 = ng > 0;
            m_rw2 = ng > 1;
            if (ng == 1) begin
                m_d1  = dst_of(g[0]);
                m_wd1 = req_data[32*g[0] +: 32];
            end else if (ng == 2) begin
                lo = (g[0] < g[1]) ? g[0] : g[1];
                hi = (g[0] < g[1]) ? g[1] : g[0];
                m_d1  = dst_of(lo);
                m_wd1 = req_data[32*lo +: 32];
                m_d2  = dst_of(hi);
                m_wd2 = req_data[32*hi +: 32];
            end
            if (ng > 0) m_rr = (last + 1) % 3;
            m_cnt = (m_cnt + r0n > 65535) ? 65535 : m_cnt + r0n;
        end
        #1;
        chk("rw1", 64'(regWrite1), 64'(m_rw1));
        chk("rw2", 64'(regWrite2), 64'(m_rw2));
        chk("dec1", 64'(decOut1), m_rw1 ? 64'(1) << m_d1 : 64'(0));
        chk("dec2", 64'(decOut2), m_rw2 ? 64'(1) << m_d2 : 64'(0));
        chk("wd1", 64'(writeData1), 64'(m_wd1));
        chk("wd2", 64'(writeData2), 64'(m_wd2));
        chk("busy", 64'(wr_busy), (m_rw1 ? 64'(1) << m_d1 : 64'(0)) |
                                  (m_rw2 ? 64'(1) << m_d2 : 64'(0)));
        chk("cnt", 64'(r0_drop_cnt), 64'(m_cnt));
    endtask

    task automatic put(input int i, input int d, input logic [31:0] x);
        req_valid[i]      = 1'b1;
        req_dest[3*i +: 3] = 3'(d);
        req_data[32*i +: 32] = x;
    endtask

    initial begin
        bit pv [3];
        m_rr = 0; m_cnt = 0; m_rw1 = 0; m_rw2 = 0;
        m_wd1 = '0; m_wd2 = '0; m_d1 = 0; m_d2 = 0;
        for (int k = 0; k < 8; k++) begin
            mrf[k] = '0;
            rf[k]  = '0;
        end
        req_valid = '0; req_dest = '0; req_data = '0; reset = 1'b0;
        @(posedge clk); #1;

        // reset held with all requesters valid
        put(0, 1, 32'h11); put(1, 2, 32'h22); put(2, 3, 32'h33);
        cyc(1'b0);
        cyc(1'b0);
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_cnt", 64'(r0_drop_cnt), 64'(0));

        // three distinct destinations
        cyc(1'b1);
        chk("t3_acc", 64'(m_acc), 64'h3);
        chk("t3_dec1", 64'(decOut1), 64'h02);
        chk("t3_dec2", 64'(decOut2), 64'h04);
        chk("t3_busy", 64'(wr_busy), 64'h06);
        req_valid[1] = 1'b0;
        cyc(1'b1);
        chk("t3_acc2", 64'(m_acc), 64'h5);
        chk("t3_p1", 64'(writeData1), 64'h11);
        chk("t3_p2", 64'(writeData2), 64'h33);
        req_valid = '0;
        cyc(1'b1);

        // same-destination ordering
        put(0, 5, 32'hAAAA); put(2, 5, 32'hBBBB);
        cyc(1'b1);
        chk("sd_acc", 64'(m_acc), 64'h1);
        chk("sd_wd1", 64'(writeData1), 64'hAAAA);
        req_valid[0] = 1'b0;
        cyc(1'b1);
        chk("sd_wd1b", 64'(writeData1), 64'hBBBB);
        req_valid = '0;
        cyc(1'b1);
        cyc(1'b1);
        chk("sd_r5", 64'(rf[5]), 64'hBBBB);

        // R0 drops alongside a single real write
        put(1, 0, 32'hDEAD); put(0, 4, 32'h44);
        cyc(1'b1);
        chk("r0_acc", 64'(m_acc), 64'h3);
        chk("r0_rw2", 64'(regWrite2), 64'h0);
        chk("r0_dec1", 64'(decOut1), 64'h10);
        req_valid[0] = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        chk("r0_cnt", 64'(r0_drop_cnt), 64'h3);
        req_valid = '0;

        // reset right after a grant
        put(0, 6, 32'h66);
        cyc(1'b1);
        cyc(1'b0);
        chk("mr_rw1", 64'(regWrite1), 64'h0);
        chk("mr_rw2", 64'(regWrite2), 64'h0);
        req_valid = '0;
        cyc(1'b1);

        // random held-valid traffic
        for (int i = 0; i < 3; i++) pv[i] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pv[i] && $urandom_range(0, 9) < 6) begin
                    pv[i] = 1;
                    put(i, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3)
                                                       : $urandom_range(0, 7),
                        $urandom);
                end
                req_valid[i] = pv[i];
            end
            cyc(1'b1);
            for (int i = 0; i < 3; i++) if (m_acc[i]) pv[i] = 0;
        end
        req_valid = '0;
        cyc(1'b1);
        cyc(1'b1);
        for (int k = 0; k < 8; k++) chk("rf", 64'(rf[k]), 64'(mrf[k]));

        // counter saturation
        cyc(1'b0);
        put(0, 0, 32'h1); put(1, 0, 32'h2); put(2, 0, 32'h3);
        for (int n = 0; n < 21845; n++) cyc(1'b1);
        chk("sat_full", 64'(r0_drop_cnt), 64'hFFFF);
        cyc(1'b1);
        chk("sat_hold", 64'(r0_drop_cnt), 64'hFFFF);
        req_valid = '0;
        cyc(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_write_scheduler.md
Name: wb_write_scheduler

Overview:
- Write-back scheduler for the 8x32 dual-write-port register set.
- Collects results from three write-back sources: req 0 = ALU0 (oldest), req 1 = ALU1, req 2 = LOAD (youngest).
- Allocates at most two register-file write ports per cycle and keeps same-register writes in order.
- Drives regWrite1/2, one-hot decOut1/2 and writeData1/2 directly into the register set. R0 writes are consumed and dropped.

Parameters:
- NREQ, 3, number of write-back requesters (fixed; 3 is the only supported value)
- DW, 32, data width
- NREG, 8, register count; a destination is log2(NREG)=3 bits
- CNTW, 16, width of the R0-drop counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- req_valid  in  3  per-requester write request
- req_dest  in  9  destinations, 3 bits each; bits [3i+2:3i] belong to requester i
- req_data  in  96  data, 32 bits each; bits [32i+31:32i] belong to requester i
- req_ready  out  3  accept strobe, combinational from req_valid/req_dest/rr state
- regWrite1  out  1  port-1 write enable (registered)
- decOut1  out  8  port-1 one-hot destination (registered)
- writeData1  out  32  port-1 data (registered)
- regWrite2  out  1  port-2 write enable (registered)
- decOut2  out  8  port-2 one-hot destination (registered)
- writeData2  out  32  port-2 data (registered)
- wr_busy  out  8  registered: decOut1&{8{regWrite1}} | decOut2&{8{regWrite2}}
- r0_drop_cnt  out  16  saturating count of accepted R0 writes

Behaviour:
- Reset (reset==0 at posedge): all registered outputs and r0_drop_cnt go to 0; rr pointer goes to 0. req_ready is 0 while reset is low.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i] at a posedge. The requester holds valid, dest and data stable until accepted. Valid must not drop before acceptance.
- R0 request (dest==0): always eligible and always ready. It uses no port and no write is issued. r0_drop_cnt increments and saturates at 0xFFFF.
- Same-destination conflict: request i is blocked (ready=0) if any valid request j<i has the same non-zero dest. Only the oldest of a conflicting group competes. The blocked writer retries next cycle, so the older write always lands first.
- Port allocation:
  - Eligible non-R0 requests are scanned in order rr, rr+1, rr+2 (mod 3); the first two found are granted.
  - Port 1 takes the lower-index grant and port 2 the higher.
  - A single grant always uses port 1; regWrite2=0.
- rr update: when at least one non-R0 grant occurs, rr <= (index of last granted in scan order + 1) mod 3. Otherwise rr holds.
- Latency: accepted at edge N, then regWrite/decOut/writeData are valid during cycle N+1 for exactly one cycle. The write commits into the register set at edge N+1. With no grant, regWrite1/2=0 and decOut1/2=0; writeData is don't-care (hold the previous value).
- Ports 1 and 2 never carry the same destination in one cycle.
- Fairness: with no same-dest conflicts, a continuously valid request is granted within 2 cycles.
- Reset mid-operation: registered writes pending for the next cycle are discarded (regWrite forced to 0). In-flight requests are not accepted and must be re-presented by the sources.

Decomposition:
- Shared package: DW, NREG, CNTW; requester index constants REQ_ALU0=0, REQ_ALU1=1, REQ_LOAD=2; a 3-to-8 one-hot decode function.
- One sub-module, wb_rr_pick2: combinational round-robin picker.
  - Inputs: 3-bit eligible mask, 2-bit rr.
  - Outputs: two grant indices with valid bits, plus next_rr.
- Top level holds the conflict masking, output registers, rr register and counter.

Test Plan:
- Reset: hold reset=0 for 2 cycles with all req_valid=1 -> req_ready=000; all outputs 0; r0_drop_cnt=0. After release, first grants go to req 0 and 1.
- Three distinct dests: req0 R1=0x11, req1 R2=0x22, req2 R3=0x33, held valid.
  - Cycle 1: accepts 0,1; next cycle port1=R1/0x11 (decOut1=0x02), port2=R2/0x22 (decOut2=0x04), wr_busy=0x06.
  - Cycle 2: accepts 2 and a re-presented 0 (rr=2); 0 goes on port 1, 2 on port 2.
- Same-dest ordering: req0 R5=0xAAAA and req2 R5=0xBBBB in the same cycle -> req_ready=x01 with req2 blocked. R5 gets 0xAAAA at N+1, then 0xBBBB at N+2; R5 final value 0xBBBB.
- R0 drop: req1 dest 0 for 3 cycles plus req0 R4 -> req1 accepted every cycle with no port used; r0_drop_cnt=3. Only port 1 is active for R4.
- Counter saturation: preload via 65535 R0 writes, then one more -> r0_drop_cnt stays 0xFFFF.
- Reset mid-stream: assert reset the cycle after a grant -> regWrite1/2 are 0 in the following cycle; no register-set write occurs.
